datamem_arbiter: RTL and testbench
==================================

# datamem_arbiter

Parametrised data-memory arbiter between the CPU data port and `NUM_ACCEL` accelerator request channels. Accelerator requests are buffered in one FIFO per channel and served round-robin. The CPU has priority, bounded by a starvation guard. Grants go to a single synchronous memory port, and read data is routed back to the issuing requester one cycle later. Each request is bounds-checked before issue.

## Interface
- `NUM_ACCEL`, 2: accelerator channels (1–8)
- `ADDR_W`, 16: byte address width
- `DATA_W`, 32: write word / CPU read width
- `LINE_W`, 512: memory read line width
- `MEM_SIZE`, 65536: memory size in bytes
- `FIFO_DEPTH`, 4: per-channel request FIFO entries (power of 2)
- `STARVE_LIMIT`, 8: consecutive CPU grants allowed while any accelerator FIFO is non-empty
- `clk` in 1: clock
- `rst_n` in 1: asynchronous active-low reset
- `cpu_addr` in ADDR_W: CPU byte address
- `cpu_wrt_data` in DATA_W: CPU write data
- `cpu_wrt_en` in 1: CPU write request
- `cpu_rd_en` in 1: CPU read request
- `cpu_stall` out 1: CPU request not accepted this cycle; CPU holds its request
- `cpu_rd_valid` out 1: `cpu_rd_data` valid
- `cpu_rd_data` out DATA_W: bits [DATA_W-1:0] of the returned line
- `cpu_err` out 1: one-cycle pulse, CPU request out of bounds (dropped)
- `accel_req_valid` in NUM_ACCEL: per-channel request valid
- `accel_req_ready` out NUM_ACCEL: per-channel FIFO not full
- `accel_addr` in NUM_ACCEL*ADDR_W: packed addresses, channel i at [i*ADDR_W +: ADDR_W]
- `accel_wrt_data` in NUM_ACCEL*DATA_W: packed write data
- `accel_wrt_en` in NUM_ACCEL: 1 = write, 0 = read
- `accel_rd_valid` out NUM_ACCEL: one-hot, returned line belongs to channel i
- `accel_rd_data` out LINE_W: shared returned line
- `accel_err` out NUM_ACCEL: one-cycle pulse, channel request out of bounds (dropped)
- `mem_addr` out ADDR_W, `mem_wrt_data` out DATA_W, `mem_wrt_en` out 1, `mem_rd_en` out 1: memory port
- `mem_rd_data` in LINE_W: memory line, valid the cycle after `mem_rd_en`

## Operation
- **Enqueue:** channel i accepts a request when `accel_req_valid[i] && accel_req_ready[i]`. The FIFO entry holds {addr, data, wrt_en}. The FIFO is first-word-fall-through. A push and a pop in the same cycle on a full FIFO are both legal, and the occupancy is unchanged.
- **CPU requests:** `cpu_req = cpu_wrt_en | cpu_rd_en`. If both enables are set, the request is a write.
- **Grant:**
  - The CPU wins if `cpu_req` and `starve_cnt < STARVE_LIMIT`.
  - Otherwise the round-robin pointer selects the first non-empty FIFO at or after `rr_ptr`. That FIFO pops, and `rr_ptr` becomes the winner index + 1, modulo NUM_ACCEL.
- **Starvation counter:**
  - `starve_cnt` increments on every CPU grant while any FIFO is non-empty.
  - It clears on any accelerator grant, or when all FIFOs are empty.
  - `cpu_stall = cpu_req && !cpu_grant`.
- **Bounds check** on the selected request, before issue:
  - A write is an error if `addr > MEM_SIZE-4`.
  - A CPU read is an error if `addr > MEM_SIZE-4`.
  - An accelerator read is an error if `addr > MEM_SIZE-64`.
  - An erroring request is consumed (CPU not stalled, FIFO popped), drives no memory enable, and pulses its err bit.
- **Return routing:** a 1-entry tag register {valid, is_cpu, chan} is captured on each issued read. The next cycle it drives `cpu_rd_valid` or `accel_rd_valid[chan]`.
- `accel_rd_data` and `cpu_rd_data` pass `mem_rd_data` combinationally. They are don't-care when their valid is low.

## Timing
- **Reset values:** all outputs are 0 except `accel_req_ready`, which is all ones. FIFOs are empty, `rr_ptr` = 0, `starve_cnt` = 0, tag invalid.
- **Reset mid-operation:** queued requests are discarded and any pending read return is lost.
- **Accelerator latency:** enqueue at cycle t, earliest issue at t+1, read data at t+2.
- **CPU latency:** issue in the same cycle as the request (combinational grant), read data the next cycle.
- **Memory port:** at most one operation per cycle. `mem_wrt_en` and `mem_rd_en` are never both high.
- **Ready timing:** `accel_req_ready[i]` is registered occupancy < FIFO_DEPTH. It does not account for a same-cycle pop.
- **Round-robin pointer:** `rr_ptr` advances only on an accelerator grant, including an erroring one.

## Structure
- Package `datamem_arb_pkg`:
  - `typedef struct packed {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; logic wrt_en;} dm_req_t`
  - the return-tag struct
  - constants `DM_WORD_BYTES=4` and `DM_LINE_BYTES=64`
- Sub-module `datamem_req_fifo`, parametrised on width and depth, instantiated NUM_ACCEL times.
- The arbiter, starvation counter, bounds check and return tag live in the top level.

## Test plan
- **CPU read:** CPU read at 0x0100 while all FIFOs are empty -> `mem_rd_en` in the same cycle, `cpu_rd_valid` next cycle with `mem_rd_data[31:0]`, `cpu_stall` = 0.
- **Round robin:** ch0 and ch1 each enqueue 2 reads, no CPU traffic -> issue order ch0, ch1, ch0, ch1; `accel_rd_valid` = 01, 10, 01, 10 on consecutive cycles.
- **Starvation guard:** CPU requests continuously while ch1 holds 1 entry, STARVE_LIMIT = 8 -> 8 CPU grants, then `cpu_stall` = 1 for exactly 1 cycle while ch1 issues, then CPU grants resume.
- **Full FIFO:** ch0 pushes 4 with no pops -> `accel_req_ready[0]` = 0; a 5th valid is not accepted; after 1 pop, ready = 1 the next cycle.
- **Bounds:** accelerator read at 0xFFC1 -> `accel_err` pulses for 1 cycle, no memory enable, FIFO popped. CPU write at 0xFFFC is accepted; CPU write at 0xFFFD -> `cpu_err`.
- **Reset mid-operation:** assert `rst_n` low with 3 entries queued and a read in flight -> all valid outputs are 0 immediately, the FIFOs are empty after release, and no return appears.

Source files
------------

// File: rtl/datamem_arbiter_pkg.sv
// Shared types, constants and the bounds-check helper for the data-memory arbiter.
package datamem_arb_pkg;

    localparam int unsigned DM_WORD_BYTES = 32'd4;
    localparam int unsigned DM_LINE_BYTES = 32'd64;
    localparam int unsigned DM_ADDR_W     = 32'd16;
    localparam int unsigned DM_DATA_W     = 32'd32;

    // Queued accelerator request, default-configuration widths.
    typedef struct packed {
        logic [DM_ADDR_W-1:0] addr;
        logic [DM_DATA_W-1:0] data;
        logic                 wrt_en;
    } dm_req_t;

    // Return tag: which requester owns the line arriving next cycle.
    typedef struct packed {
        logic       valid;
        logic       is_cpu;
        logic [2:0] chan;
    } dm_tag_t;

    // True when an access of 'span' bytes starting at 'addr' runs past the memory.
    function automatic logic dm_out_of_bounds(input logic [31:0] addr,
                                              input logic [31:0] mem_size,
                                              input logic [31:0] span);
        return (addr > (mem_size - span));
    endfunction

endpackage

// File: rtl/datamem_req_fifo.sv
// First-word-fall-through request FIFO; a push is allowed on a full FIFO when it pops in the same cycle.
module datamem_req_fifo #(
    parameter int unsigned WIDTH = 32'd49,
    parameter int unsigned DEPTH = 32'd4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned PTR_W = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 32'd1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Accept/retire decisions and next pointer/occupancy values.
    always_comb begin
        do_pop_s  = pop_i && (count_q != '0);
        do_push_s = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 32'd1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 32'd1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all queued entries.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/datamem_arbiter.sv
// CPU-priority / round-robin arbiter in front of a single synchronous data-memory port.
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int NUM_ACCEL    = 2,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int LINE_W       = 512,
    parameter int MEM_SIZE     = 65536,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic [DATA_W-1:0]           cpu_wrt_data,
    input  logic                        cpu_wrt_en,
    input  logic                        cpu_rd_en,
    output logic                        cpu_stall,
    output logic                        cpu_rd_valid,
    output logic [DATA_W-1:0]           cpu_rd_data,
    output logic                        cpu_err,
    input  logic [NUM_ACCEL-1:0]        accel_req_valid,
    output logic [NUM_ACCEL-1:0]        accel_req_ready,
    input  logic [NUM_ACCEL*ADDR_W-1:0] accel_addr,
    input  logic [NUM_ACCEL*DATA_W-1:0] accel_wrt_data,
    input  logic [NUM_ACCEL-1:0]        accel_wrt_en,
    output logic [NUM_ACCEL-1:0]        accel_rd_valid,
    output logic [LINE_W-1:0]           accel_rd_data,
    output logic [NUM_ACCEL-1:0]        accel_err,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wrt_data,
    output logic                        mem_wrt_en,
    output logic                        mem_rd_en,
    input  logic [LINE_W-1:0]           mem_rd_data
);
    localparam int REQ_W  = ADDR_W + DATA_W + 1;
    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

    logic [REQ_W-1:0]     fifo_data_s [NUM_ACCEL];
    logic [NUM_ACCEL-1:0] fifo_empty_s, fifo_full_s, fifo_push_s, fifo_pop_s;
    logic [2:0]           rr_ptr_q, rr_ptr_d, win_idx_s;
    logic [SCNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    dm_tag_t              tag_q, tag_d;
    logic                 acc_any_s, win_found_s, cpu_req_s, cpu_grant_s, acc_grant_s;
    logic                 oob_s, sel_wr_s, rd_issue_s, wr_issue_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic [DATA_W-1:0]    sel_data_s;
    logic [REQ_W-1:0]     win_req_s;
    int                   idx_s;

    for (genvar g = 0; g < NUM_ACCEL; g++) begin : g_fifo
        datamem_req_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .push_i (fifo_push_s[g]),
            .pop_i  (fifo_pop_s[g]),
            .data_i ({accel_addr[g*ADDR_W +: ADDR_W], accel_wrt_data[g*DATA_W +: DATA_W], accel_wrt_en[g]}),
            .data_o (fifo_data_s[g]),
            .empty_o(fifo_empty_s[g]),
            .full_o (fifo_full_s[g])
        );
    end

    // Round-robin search: first non-empty FIFO at or after the pointer.
    always_comb begin
        acc_any_s   = 1'b0;
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        idx_s       = 0;
        win_req_s   = '0;
        for (int k = 0; k < NUM_ACCEL; k++) begin
            idx_s = (int'(rr_ptr_q) + k) % NUM_ACCEL;
            if (!fifo_empty_s[idx_s]) begin
                acc_any_s = 1'b1;
                if (!win_found_s) begin
                    win_found_s = 1'b1;
                    win_idx_s   = 3'(idx_s);
                end else begin
                    win_found_s = 1'b1;
                end
            end else begin
                acc_any_s = acc_any_s;
            end
        end
        for (int i = 0; i < NUM_ACCEL; i++) begin
            if (win_idx_s == 3'(i)) begin
                win_req_s = fifo_data_s[i];
            end else begin
                win_req_s = win_req_s;
            end
        end
    end

    // Grant, request selection, bounds check and memory-port drive.
    always_comb begin
        cpu_req_s   = rst_n && (cpu_wrt_en || cpu_rd_en);
        cpu_grant_s = cpu_req_s && ((starve_cnt_q < SCNT_W'(STARVE_LIMIT)) || !acc_any_s);
        acc_grant_s = !cpu_grant_s && acc_any_s;
        sel_addr_s  = '0;
        sel_data_s  = '0;
        sel_wr_s    = 1'b0;
        oob_s       = 1'b0;
        if (cpu_grant_s) begin
            sel_addr_s = cpu_addr;
            sel_data_s = cpu_wrt_data;
            sel_wr_s   = cpu_wrt_en;
            oob_s      = dm_out_of_bounds(32'(cpu_addr), 32'(MEM_SIZE), 32'(DM_WORD_BYTES));
        end else if (acc_grant_s) begin
            {sel_addr_s, sel_data_s, sel_wr_s} = win_req_s;
            oob_s = dm_out_of_bounds(32'(sel_addr_s), 32'(MEM_SIZE),
                                     sel_wr_s ? 32'(DM_WORD_BYTES) : 32'(DM_LINE_BYTES));
        end else begin
            oob_s = 1'b0;
        end
        rd_issue_s = (cpu_grant_s || acc_grant_s) && !sel_wr_s && !oob_s;
        wr_issue_s = (cpu_grant_s || acc_grant_s) && sel_wr_s && !oob_s;
        for (int i = 0; i < NUM_ACCEL; i++) begin
            fifo_pop_s[i]  = acc_grant_s && (win_idx_s == 3'(i));
            accel_err[i]   = acc_grant_s && oob_s && (win_idx_s == 3'(i));
            fifo_push_s[i] = accel_req_valid[i] && !fifo_full_s[i];
        end
    end

    // Next pointer, starvation count and return tag.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        tag_d        = '0;
        if (acc_grant_s) begin
            rr_ptr_d = (win_idx_s == 3'(NUM_ACCEL - 1)) ? 3'd0 : win_idx_s + 3'd1;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        if (acc_grant_s || !acc_any_s) begin
            starve_cnt_d = '0;
        end else if (cpu_grant_s && (starve_cnt_q < SCNT_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + SCNT_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
        tag_d.valid  = rd_issue_s;
        tag_d.is_cpu = cpu_grant_s;
        tag_d.chan   = cpu_grant_s ? 3'd0 : win_idx_s;
    end

    // Arbitration state registers; reset drops any in-flight read return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= 3'd0;
            starve_cnt_q <= '0;
            tag_q        <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            tag_q        <= tag_d;
        end
    end

    // Return routing from the tag captured on the issuing cycle.
    always_comb begin
        cpu_rd_valid = tag_q.valid && tag_q.is_cpu;
        for (int i = 0; i < NUM_ACCEL; i++) begin
            accel_rd_valid[i] = tag_q.valid && !tag_q.is_cpu && (tag_q.chan == 3'(i));
        end
    end

    assign accel_req_ready = ~fifo_full_s;
    assign cpu_stall       = cpu_req_s && !cpu_grant_s;
    assign cpu_err         = cpu_grant_s && oob_s;
    assign mem_addr        = sel_addr_s;
    assign mem_wrt_data    = sel_data_s;
    assign mem_rd_en       = rd_issue_s;
    assign mem_wrt_en      = wr_issue_s;
    assign cpu_rd_data     = mem_rd_data[DATA_W-1:0];
    assign accel_rd_data   = mem_rd_data;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed and randomized bench for datamem_arbiter against a queue-based reference model.
module tb_datamem_arbiter;
    localparam int NA = 2, AW = 16, DW = 32, LW = 512, MS = 65536, FD = 4, SL = 8;

    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; logic wr; } req_t;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] cpu_addr, mem_addr;
    logic [DW-1:0] cpu_wrt_data, cpu_rd_data, mem_wrt_data;
    logic cpu_wrt_en, cpu_rd_en, cpu_stall, cpu_rd_valid, cpu_err, mem_wrt_en, mem_rd_en;
    logic [NA-1:0] accel_req_valid, accel_req_ready, accel_wrt_en, accel_rd_valid, accel_err;
    logic [NA*AW-1:0] accel_addr;
    logic [NA*DW-1:0] accel_wrt_data;
    logic [LW-1:0] accel_rd_data, mem_rd_data, mem_line;

    datamem_arbiter #(.NUM_ACCEL(NA), .ADDR_W(AW), .DATA_W(DW), .LINE_W(LW), .MEM_SIZE(MS),
                      .FIFO_DEPTH(FD), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wrt_data(cpu_wrt_data),
        .cpu_wrt_en(cpu_wrt_en), .cpu_rd_en(cpu_rd_en), .cpu_stall(cpu_stall),
        .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data), .cpu_err(cpu_err),
        .accel_req_valid(accel_req_valid), .accel_req_ready(accel_req_ready),
        .accel_addr(accel_addr), .accel_wrt_data(accel_wrt_data), .accel_wrt_en(accel_wrt_en),
        .accel_rd_valid(accel_rd_valid), .accel_rd_data(accel_rd_data), .accel_err(accel_err),
        .mem_addr(mem_addr), .mem_wrt_data(mem_wrt_data), .mem_wrt_en(mem_wrt_en),
        .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data));

    // Memory line pattern: each 32-bit word distinct and tied to the address.
    function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = {a, ~a} + 32'(k * 32'h01010101);
        return l;
    endfunction

    // Synchronous memory stand-in: line appears the cycle after the read.
    always @(posedge clk) if (mem_rd_en) mem_line <= pat(mem_addr);
    assign mem_rd_data = mem_line;

    int nvec = 0, nerr = 0, stall_seen = 0;
    // Reference model state
    req_t mq [NA][$];
    int rr = 0, starve = 0;
    bit pend_v = 0, pend_cpu = 0;
    int pend_ch = 0;
    logic [AW-1:0] pend_addr = '0;
    // Stimulus variables
    logic c_wr = 0, c_rd = 0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_data = '0;
    logic [NA-1:0] a_v = '0, a_wr = '0;
    logic [AW-1:0] a_addr [NA];
    logic [DW-1:0] a_data [NA];

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        c_wr = 0; c_rd = 0; a_v = '0;
    endtask

    // One clock: drive, check against the model, advance the model.
    task automatic step();
        bit any, cw, aw, oob, sel_wr, exp_rd, exp_wr;
        int win;
        logic [AW-1:0] sel_addr;
        logic [DW-1:0] sel_data;
        logic [NA-1:0] rdy, exp_aerr, exp_arv;
        req_t r;
        cpu_addr = c_addr; cpu_wrt_data = c_data; cpu_wrt_en = c_wr; cpu_rd_en = c_rd;
        accel_req_valid = a_v; accel_wrt_en = a_wr;
        for (int i = 0; i < NA; i++) begin
            accel_addr[i*AW +: AW] = a_addr[i]; accel_wrt_data[i*DW +: DW] = a_data[i];
        end
        #1;
        any = 0; rdy = '0; win = -1;
        for (int i = 0; i < NA; i++) begin
            if (mq[i].size() > 0) any = 1;
            rdy[i] = (mq[i].size() < FD);
        end
        cw = (c_wr | c_rd) && (starve < SL || !any);
        aw = !cw && any;
        sel_addr = '0; sel_data = '0; sel_wr = 0; oob = 0;
        if (cw) begin
            sel_addr = c_addr; sel_data = c_data; sel_wr = c_wr;
            oob = int'(c_addr) > MS - 4;
        end else if (aw) begin
            for (int k = 0; k < NA; k++)
                if (win < 0 && mq[(rr + k) % NA].size() > 0) win = (rr + k) % NA;
            r = mq[win][0];
            sel_addr = r.addr; sel_data = r.data; sel_wr = r.wr;
            oob = int'(r.addr) > (r.wr ? MS - 4 : MS - 64);
        end
        exp_rd = (cw || aw) && !sel_wr && !oob;
        exp_wr = (cw || aw) && sel_wr && !oob;
        exp_aerr = (aw && oob) ? NA'(1 << win) : '0;
        exp_arv = (pend_v && !pend_cpu) ? NA'(1 << pend_ch) : '0;
        if (cpu_stall) stall_seen++;
        chk("cpu_stall", LW'(cpu_stall), LW'((c_wr | c_rd) && !cw));
        chk("mem_rd_en", LW'(mem_rd_en), LW'(exp_rd));
        chk("mem_wrt_en", LW'(mem_wrt_en), LW'(exp_wr));
        if (exp_rd || exp_wr) chk("mem_addr", LW'(mem_addr), LW'(sel_addr));
        if (exp_wr) chk("mem_wrt_data", LW'(mem_wrt_data), LW'(sel_data));
        chk("cpu_err", LW'(cpu_err), LW'(cw && oob));
        chk("accel_err", LW'(accel_err), LW'(exp_aerr));
        chk("cpu_rd_valid", LW'(cpu_rd_valid), LW'(pend_v && pend_cpu));
        chk("accel_rd_valid", LW'(accel_rd_valid), LW'(exp_arv));
        chk("accel_req_ready", LW'(accel_req_ready), LW'(rdy));
        if (pend_v && pend_cpu) chk("cpu_rd_data", LW'(cpu_rd_data), LW'(pat(pend_addr)) & LW'(32'hFFFFFFFF));
        if (pend_v && !pend_cpu) chk("accel_rd_data", accel_rd_data, pat(pend_addr));
        @(posedge clk);
        if (aw) begin void'(mq[win].pop_front()); rr = (win + 1) % NA; end
        for (int i = 0; i < NA; i++)
            if (a_v[i] && rdy[i]) mq[i].push_back('{addr: a_addr[i], data: a_data[i], wr: a_wr[i]});
        if (aw || !any) starve = 0; else if (cw) starve++;
        pend_v = exp_rd; pend_cpu = cw; pend_ch = win; pend_addr = sel_addr;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_rd_valid"}, LW'(cpu_rd_valid), LW'(0));
        chk({tag, "_accel_rd_valid"}, LW'(accel_rd_valid), LW'(0));
        chk({tag, "_mem_en"}, LW'({mem_rd_en, mem_wrt_en}), LW'(0));
        chk({tag, "_stall_err"}, LW'({cpu_stall, cpu_err, accel_err}), LW'(0));
        chk({tag, "_ready"}, LW'(accel_req_ready), LW'({NA{1'b1}}));
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a;
        int sel;
        a = AW'($urandom);
        sel = int'($urandom_range(0, 7));
        if (sel == 0) a = 16'hFFC0 | {10'd0, a[5:0]};
        else if (sel == 1) a = 16'hFFF8 | {13'd0, a[2:0]};
        return a;
    endfunction

    initial begin
        for (int i = 0; i < NA; i++) begin a_addr[i] = '0; a_data[i] = '0; end
        cpu_addr = '0; cpu_wrt_data = '0; cpu_wrt_en = 0; cpu_rd_en = 0;
        accel_req_valid = '0; accel_addr = '0; accel_wrt_data = '0; accel_wrt_en = '0;
        @(negedge clk); #1;
        check_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;

        // CPU read with empty FIFOs
        c_rd = 1; c_addr = 16'h0100; step(); idle_inputs(); step();

        // Round robin: two reads per channel
        a_v = 2'b11; a_wr = 2'b00; a_addr[0] = 16'h1000; a_addr[1] = 16'h2000; step();
        a_addr[0] = 16'h1040; a_addr[1] = 16'h2040; step();
        idle_inputs(); repeat (5) step();

        // Starvation guard: CPU reads continuously while ch1 holds one entry
        stall_seen = 0;
        c_rd = 1; c_addr = 16'h0200; a_v = 2'b10; a_addr[1] = 16'h3000; step();
        a_v = '0; repeat (13) step();
        chk("starve_stall_cycles", LW'(stall_seen), LW'(1));
        idle_inputs(); step();

        // Full FIFO on ch0 while the CPU keeps the port busy
        c_rd = 1; c_addr = 16'h0300; a_v = 2'b01; a_wr = 2'b01;
        for (int n = 0; n < 5; n++) begin a_addr[0] = AW'(16'h4000 + n * 4); a_data[0] = DW'(n); step(); end
        a_v = '0; repeat (7) step();
        idle_inputs(); repeat (6) step();

        // Bounds
        a_v = 2'b01; a_wr = 2'b00; a_addr[0] = 16'hFFC1; step();
        a_v = 2'b01; a_addr[0] = 16'hFFC0; step(); a_v = '0; repeat (3) step();
        c_wr = 1; c_data = 32'hCAFEF00D; c_addr = 16'hFFFC; step();
        c_addr = 16'hFFFD; step();
        c_wr = 0; c_rd = 1; c_addr = 16'hFFFD; step(); idle_inputs(); step();

        // Reset with three entries queued and a CPU read in flight
        c_rd = 1; c_addr = 16'h0500; a_v = 2'b11; a_wr = 2'b00; a_addr[0] = 16'h5000; a_addr[1] = 16'h6000; step();
        a_v = 2'b01; a_addr[0] = 16'h5040; step();
        a_v = '0; step();
        chk("inflight_before_reset", LW'(cpu_rd_valid), LW'(1));
        idle_inputs(); cpu_rd_en = 0; cpu_wrt_en = 0; accel_req_valid = '0;
        rst_n = 1'b0; #1;
        check_reset_outputs("midreset");
        for (int i = 0; i < NA; i++) mq[i].delete();
        rr = 0; starve = 0; pend_v = 0;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            c_rd = ($urandom_range(0, 3) == 0); c_wr = ($urandom_range(0, 5) == 0);
            c_addr = rnd_addr(); c_data = $urandom;
            for (int i = 0; i < NA; i++) begin
                a_v[i] = $urandom_range(0, 1); a_wr[i] = ($urandom_range(0, 2) == 0);
                a_addr[i] = rnd_addr(); a_data[i] = $urandom;
            end
            step();
        end
        idle_inputs(); repeat (12) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
